ex_flag_stage: RTL

EX_FLAG_STAGE -- requirements
Module: ex_flag_stage

---
 rtl/ex_flag_stage_if.sv | 27 ++
 rtl/ex_flag_stage.sv | 131 +++++++++++++
 2 files changed

// File: rtl/ex_flag_stage_if.sv
// ex_flag_stage_if: EX-side bus into the flag/EX-MEM stage.
//   alu_result, alu_v, alu_n : ALU result and its overflow/sign flags
//   ex_valid                 : EX holds a real instruction
//   ex_op, ex_dst, ex_regwrite : opcode, destination register, write enable
//   br_valid, br_cond        : branch in EX and its condition code
// master drives the bus (decode/ALU side), slave is the flag stage.
interface ex_flag_stage_if;
   logic [15:0] alu_result;
   logic        alu_v;
   logic        alu_n;
   logic        ex_valid;
   logic [3:0]  ex_op;
   logic [3:0]  ex_dst;
   logic        ex_regwrite;
   logic        br_valid;
   logic [2:0]  br_cond;

   modport master (
      output alu_result, alu_v, alu_n, ex_valid, ex_op, ex_dst, ex_regwrite,
             br_valid, br_cond
   );

   modport slave (
      input  alu_result, alu_v, alu_n, ex_valid, ex_op, ex_dst, ex_regwrite,
             br_valid, br_cond
   );
endinterface

// File: rtl/ex_flag_stage.sv
// ex_flag_stage: EX/MEM pipeline register, architectural V/N/Z flag register
// and registered branch resolution.
//   clk, rst      : clock, synchronous active-high reset
//   ex            : EX-side bus (ex_flag_stage_if.slave)
//   stall, flush  : hold the stage / kill the EX instruction
//   mem_result, mem_dst, mem_regwrite, mem_valid : EX/MEM register
//   flag_v, flag_n, flag_z : flag register
//   br_taken, br_resolved  : registered branch outcome
// Optional feature: define FLAG_BYPASS_EN to evaluate branches against the
// next-state flag value instead of the flag register output.
module ex_flag_stage (
   input  logic                 clk,
   input  logic                 rst,
   ex_flag_stage_if.slave       ex,
   input  logic                 stall,
   input  logic                 flush,
   output logic [15:0]          mem_result,
   output logic [3:0]           mem_dst,
   output logic                 mem_regwrite,
   output logic                 mem_valid,
   output logic                 flag_v,
   output logic                 flag_n,
   output logic                 flag_z,
   output logic                 br_taken,
   output logic                 br_resolved
);

   localparam int unsigned DATA_W = 16;
   localparam int unsigned OP_W   = 4;

   localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
   localparam logic [OP_W-1:0] OP_SUB = 4'b0010;

   logic accept;
   logic bubble;
   logic is_alu;
   logic is_arith;
   logic upd_z;
   logic upd_vn;
   logic res_zero;
   logic fv_nxt;
   logic fn_nxt;
   logic fz_nxt;
   logic src_v;
   logic src_n;
   logic src_z;
   logic cond_met;

   // Acceptance, bubble and flag-update qualification
   always_comb begin
      accept   = ex.ex_valid & ~stall & ~flush;
      bubble   = flush | (~stall & ~ex.ex_valid);
      is_alu   = ~ex.ex_op[3];
      is_arith = (ex.ex_op == OP_ADD) || (ex.ex_op == OP_SUB);
      // A branch never writes flags, whatever its ex_op carries
      upd_z    = accept & ~ex.br_valid & is_alu;
      upd_vn   = upd_z & is_arith;
      res_zero = (ex.alu_result == DATA_W'(0));
   end

   // Next-state flag values; equal to the register when no update occurs
   always_comb begin
      fv_nxt = upd_vn ? ex.alu_v : flag_v;
      fn_nxt = upd_vn ? ex.alu_n : flag_n;
      fz_nxt = upd_z  ? res_zero : flag_z;
   end

   // Branch flag source. The bypass path reads the next-state mux; because a
   // branch suppresses its own flag update, it resolves identically to the
   // register, but the source differs structurally.
   always_comb begin
`ifdef FLAG_BYPASS_EN
      src_v = fv_nxt;
      src_n = fn_nxt;
      src_z = fz_nxt;
`else
      src_v = flag_v;
      src_n = flag_n;
      src_z = flag_z;
`endif
   end

   // Condition code evaluation
   always_comb begin
      cond_met = 1'b0;
      case (ex.br_cond)
         3'b000:  cond_met = ~src_z;
         3'b001:  cond_met = src_z;
         3'b010:  cond_met = ~src_z & ~src_n;
         3'b011:  cond_met = src_n;
         3'b100:  cond_met = src_z | ~src_n;
         3'b101:  cond_met = src_z | src_n;
         3'b110:  cond_met = src_v;
         default: cond_met = 1'b1;
      endcase
   end

   // EX/MEM register, flags and branch outcome
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_result   <= '0;
         mem_dst      <= '0;
         mem_regwrite <= 1'b0;
         mem_valid    <= 1'b0;
         flag_v       <= 1'b0;
         flag_n       <= 1'b0;
         flag_z       <= 1'b0;
         br_taken     <= 1'b0;
         br_resolved  <= 1'b0;
      end else begin
         flag_v <= fv_nxt;
         flag_n <= fn_nxt;
         flag_z <= fz_nxt;
         if (bubble) begin
            // Result and destination deliberately hold across a bubble
            mem_regwrite <= 1'b0;
            mem_valid    <= 1'b0;
            br_taken     <= 1'b0;
            br_resolved  <= 1'b0;
         end else if (accept) begin
            mem_result   <= ex.alu_result;
            mem_dst      <= ex.ex_dst;
            mem_regwrite <= ex.ex_regwrite;
            mem_valid    <= 1'b1;
            br_taken     <= ex.br_valid & cond_met;
            br_resolved  <= ex.br_valid;
         end
      end
   end

endmodule
